nibble_packer: RTL and testbench
================================

// Module: nibble_packer
// PURPOSE
//   Upstream feeder for the vector concatenation stage. Accepts a stream of
//   4-bit nibbles over a valid/ready handshake and packs NIBBLES of them into
//   one word. With the default NIBBLES=3 the word is 12 bits, matching the
//   12-bit concatenated vector the next stage consumes. Packing is
//   little-endian: nibble 0 goes to bits [3:0], nibble 1 to [7:4], nibble 2
//   to [11:8]. One-word accumulator plus one-word output register, so a new
//   word can be collected while the previous word waits for the consumer.
// PARAMETERS
//   NIBBLES  3   nibbles per output word; legal range 2..8
//   W        4   nibble width; fixed at 4 and not to be overridden
// PORTS
//   clk        in   1            single clock, rising edge
//   rst        in   1            asynchronous reset, active-high
//   in_valid   in   1            in_data is valid
//   in_ready   out  1            packer accepts; transfer when in_valid & in_ready
//   in_data    in   4            nibble
//   flush      in   1            synchronous; discard partial accumulator
//   out_valid  out  1            out_data holds a complete word
//   out_ready  in   1            consumer accepts; transfer when out_valid & out_ready
//   out_data   out  4*NIBBLES    packed word
//   fill       out  clog2(NIBBLES+1)  nibbles currently held in the accumulator
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is asynchronous and active-high.
//   Reset
//     - Clears the accumulator to 0 and cnt to 0; state = COLLECT.
//     - out_valid=0, out_data=0, fill=0; in_ready=1 once rst is deasserted.
//     - Reset asserted mid-word or mid-handshake drops all held data
//       immediately, with no clock edge required.
//   State machine
//     - COLLECT: in_ready=1 (0 while flush=1). Each accepted nibble is
//       written to acc[cnt*4 +: 4] and cnt increments.
//     - Completing nibble (cnt==NIBBLES-1), output register free or draining
//       this cycle: load acc with the new nibble merged into out_data, set
//       out_valid, set cnt=0, stay in COLLECT. Latency is 1 cycle from the
//       last nibble handshake to out_valid.
//     - Completing nibble, output register full and not draining: store the
//       nibble, go to FULL.
//     - FULL: in_ready=0. On an out_valid & out_ready cycle, move acc to
//       out_data, keep out_valid=1, set cnt=0 and return to COLLECT
//       (in_ready=1 on the next cycle).
//   Output register
//     - out_data and out_valid are registered.
//     - out_data is stable while out_valid & !out_ready.
//     - out_valid clears after a handshake unless a new word loads on the
//       same edge.
//   Throughput
//     - With out_ready held at 1, in_ready never deasserts and one nibble is
//       accepted per cycle sustained.
//   Flush
//     - In COLLECT: clears acc and cnt. A nibble presented in the same cycle
//       is not accepted, because in_ready=0 during flush.
//     - In FULL: discards the completed acc and returns to COLLECT.
//     - Never touches out_data or out_valid.
//   Handshake rules
//     - The packer never depends on in_valid to drive in_ready.
//     - The consumer may hold out_ready high indefinitely.
//     - in_data is ignored when in_valid=0.
//   fill
//     - fill = cnt in COLLECT, NIBBLES in FULL.
//     - Registered; updates on the edge after the accepting handshake.
// TESTING
//   1. Reset, out_ready=1, send 0x1,0x2,0x3 on consecutive cycles
//      -> out_data=0x321 with out_valid=1 exactly 1 cycle after the third
//      handshake; fill sequence 1,2,0.
//   2. out_ready=1, stream 6 nibbles 0xA..0xF back-to-back
//      -> 0xCBA then 0xFED; in_ready stays 1 throughout.
//   3. out_ready=0, send 9 nibbles 0x1..0x9
//      -> out_data=0x321 held stable; accumulator FULL with 0x654; in_ready=0
//      from nibble 7 on. Raise out_ready for 1 cycle -> out_data=0x654
//      next cycle and in_ready=1.
//   4. Send 0x7,0x8, assert flush with in_valid=1 and in_data=0x9
//      -> 0x9 not accepted, fill=0. Then send 0x1,0x2,0x3 -> out_data=0x321.
//   5. Send 0x4,0x5, pulse rst asynchronously between clock edges
//      -> out_valid=0, out_data=0, fill=0 immediately. Then 0x1,0x2,0x3
//      -> out_data=0x321.
//   6. Hold out_valid with out_ready=0 for 5 cycles while toggling in_valid
//      -> out_data unchanged; out_valid never drops before a handshake.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: packs NIBBLES little-endian 4-bit nibbles into one word.
// A one-word accumulator collects the next word while a registered output
// word waits for the consumer. When the accumulator completes a word while
// the output register is still occupied, the FSM parks in FULL until the
// output drains.
//
// Handshake semantics: a transfer happens on a rising clk edge when both
// valid and ready are high. in_ready depends only on state, flush and rst,
// never on in_valid. out_valid/out_data are registered and hold steady until
// out_valid & out_ready.
module nibble_packer #(
    parameter int NIBBLES = 3,
    parameter int W       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W*NIBBLES-1:0]         out_data,
    output logic [$clog2(NIBBLES+1)-1:0] fill
);

    localparam int CW = $clog2(NIBBLES + 1);
    localparam int DW = W * NIBBLES;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NIBBLES);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   fill_q, fill_d;

    logic            drain;
    logic            accept;
    logic [DW-1:0]   merged;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fill      = fill_q;

    // Ready to take a nibble only while collecting, not flushing, and out of reset.
    always_comb begin
        in_ready = (state_q == COLLECT) && !flush && !rst;
    end

    // Next-state, accumulator and output-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        fill_d      = fill_q;

        drain  = out_valid_q && out_ready;
        accept = in_valid && in_ready;

        // Accumulator with the incoming nibble written at slot cnt.
        merged = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                merged[i*W +: W] = in_data;
            end
        end

        // A handshake empties the output unless a new word loads below.
        if (drain) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        if (!out_valid_q || drain) begin
                            out_data_d  = merged;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end else begin
                            acc_d   = merged;
                            state_d = FULL;
                        end
                    end else begin
                        acc_d = merged;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (flush) begin
                    // Discard the completed word; any drain this cycle still empties the output.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else if (drain) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase

        fill_d = (state_d == FULL) ? FULL_CNT : cnt_d;
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            fill_q      <= fill_d;
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Testbench for nibble_packer (NIBBLES=3): table-driven vectors for the
// streaming cases plus hand-written sequences for backpressure, flush in
// FULL and asynchronous reset.
module tb_nibble_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [1:0]  fill;

    int passed;
    int total;

    nibble_packer #(.NIBBLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill      (fill)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [3:0]  d;
        logic        fl;
        logic        orr;
        logic        ir;    // expected in_ready before the edge
        logic        ov;    // expected out_valid after the edge
        logic [11:0] od;    // expected out_data after the edge
        logic [1:0]  fl_n;  // expected fill after the edge
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge; the caller checks in_ready, then calls post_edge.
    task automatic drive(input logic iv, input logic [3:0] d, input logic fl, input logic orr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = orr;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    // One accepted-or-not cycle with full output checks after the edge.
    task automatic cyc(input string name, input logic iv, input logic [3:0] d, input logic fl,
                       input logic orr, input logic ir, input logic ov,
                       input logic [11:0] od, input logic [1:0] f);
        drive(iv, d, fl, orr);
        check({name, " in_ready"}, 32'(in_ready), 32'(ir));
        post_edge();
        check({name, " out_valid"}, 32'(out_valid), 32'(ov));
        check({name, " out_data"}, 32'(out_data), 32'(od));
        check({name, " fill"}, 32'(fill), 32'(f));
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        //          iv    d     fl    or    ir    ov    od       fill
        // Test 1: 0x1,0x2,0x3 -> 0x321 one cycle after the third handshake.
        vecs[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd1};
        vecs[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd2};
        vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 2'd0};
        vecs[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd0};
        // Test 2: 0xA..0xF back-to-back -> 0xCBA, 0xFED, in_ready held high.
        vecs[4]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd1};
        vecs[5]  = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd2};
        vecs[6]  = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 12'hCBA, 2'd0};
        vecs[7]  = '{1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b0, 12'hCBA, 2'd1};
        vecs[8]  = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 12'hCBA, 2'd2};
        vecs[9]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 12'hFED, 2'd0};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFED, 2'd0};
        // Test 4: 0x7,0x8 then flush with 0x9 presented -> 0x9 dropped.
        vecs[11] = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFED, 2'd1};
        vecs[12] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFED, 2'd2};
        vecs[13] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFED, 2'd0};
        vecs[14] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFED, 2'd1};
        vecs[15] = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFED, 2'd2};
        vecs[16] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 2'd0};
        vecs[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd0};

        // Reset state.
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset fill", 32'(fill), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 18; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].orr,
                vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].fl_n);
        end

        // Test 3: backpressure, 6 nibbles fill output and accumulator.
        cyc("t3 n1", 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h321, 2'd1);
        cyc("t3 n2", 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 12'h321, 2'd2);
        cyc("t3 n3", 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd0);
        cyc("t3 n4", 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd1);
        cyc("t3 n5", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd2);
        cyc("t3 n6", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd3);
        for (int k = 7; k <= 9; k++) begin
            cyc($sformatf("t3 n%0d blocked", k), 1'b1, 4'(k), 1'b0, 1'b0,
                1'b0, 1'b1, 12'h321, 2'd3);
        end
        cyc("t3 drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h654, 2'd0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("t3 in_ready after drain", 32'(in_ready), 32'd1);
        post_edge();
        check("t3 hold 654", 32'(out_data), 32'h654);
        cyc("t3 final drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h654, 2'd0);

        // Test 6: hold output with out_ready=0 while in_valid toggles.
        cyc("t6 n1", 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h654, 2'd1);
        cyc("t6 n2", 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 12'h654, 2'd2);
        cyc("t6 n3", 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd0);
        cyc("t6 h0", 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd1);
        cyc("t6 h1", 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd1);
        cyc("t6 h2", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd2);
        cyc("t6 h3", 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd2);
        cyc("t6 h4", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 12'h321, 2'd3);
        // Flush in FULL discards 0x654; output untouched.
        cyc("t6 flush full", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h321, 2'd0);
        cyc("t6 drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd0);
        cyc("t6 empty", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd0);

        // Test 5: asynchronous reset mid-word with a word still held.
        cyc("t5 n1", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 12'h321, 2'd1);
        cyc("t5 n2", 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 12'h321, 2'd2);
        cyc("t5 n3", 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 12'h789, 2'd0);
        cyc("t5 n4", 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 12'h789, 2'd1);
        cyc("t5 n5", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 12'h789, 2'd2);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5 async out_valid", 32'(out_valid), 32'd0);
        check("t5 async out_data", 32'(out_data), 32'd0);
        check("t5 async fill", 32'(fill), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("t5 r1", 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd1);
        cyc("t5 r2", 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd2);
        cyc("t5 r3", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 2'd0);
        cyc("t5 idle", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h321, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
